// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//   Iterative unsigned shift-and-add multiplier feeding the accumulate adder of
//   the MAC datapath. One multiplier bit is retired per clock, so a product
//   takes exactly WIDTH run cycles after the operands are accepted.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operands i_a / i_b valid
//   o_in_ready   block can accept operands (high only in IDLE)
//   i_a          multiplicand, unsigned, WIDTH bits
//   i_b          multiplier, unsigned, WIDTH bits
//   o_out_valid  product o_p valid (high only in DONE)
//   i_out_ready  downstream adder consumes o_p
//   o_p          product i_a*i_b, unsigned, 2*WIDTH bits
//   o_busy       high while an operation is in RUN or DONE
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [2*WIDTH-1:0]   o_p,
   output logic                 o_busy
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_last;

   logic [WIDTH-1:0]     r_mcand;
   // {ACC_HI, ACC_LO}: the upper half accumulates partial sums, the lower half
   // starts as the multiplier and is consumed one bit per cycle from bit 0.
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_p;

   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_acc_shift;

   // One extra bit on the sum keeps the carry; the right shift moves it into
   // the top of ACC_HI, so no partial product is ever lost.
   always_comb begin
      w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      if (r_acc[0]) begin
         w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
      end
   end

   assign w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; accept only happens in IDLE, so IN_READY never
   // depends on the downstream side.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (i_out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: load on accept, shift/add every RUN cycle, capture the product
   // on the final iteration. o_p then holds until the next DONE load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcand <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
      end else if (w_accept) begin
         r_mcand <= i_a;
         r_acc   <= {{WIDTH{1'b0}}, i_b};
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_shift;
         if (w_last) begin
            // Explicit clear so the counter restarts cleanly for any WIDTH,
            // not only powers of two.
            r_cnt <= '0;
            r_p   <= w_acc_shift;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_out_valid = (r_state == S_DONE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_p         = r_p;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Self-checking bench for shift_add_multiplier (WIDTH=16): directed vector
//   table, reset mid-run, back-pressure, back-to-back throughput and a random
//   run checked against plain A*B.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] p;
   logic           busy;

   int n_vec  = 0;
   int n_miss = 0;
   int n_in   = 0;
   int n_out  = 0;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_a         (a),
      .i_b         (b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_p         (p),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   // Handshake counters (values seen before the edge's updates settle).
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)   n_in++;
      if (rst_n && out_valid && out_ready) n_out++;
   end

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      int             stall;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t vecs[10];

   function automatic void chk(input string name, input logic [63:0] got,
                               input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endfunction

   // One complete transaction: offer operands, measure latency, optionally
   // stall the output for 'stall' cycles, then consume the product.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int stall, input logic [2*W-1:0] exp,
                         input string tag);
      int lat;
      int w;
      @(negedge clk);
      a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      // Operands only matter at the accept edge.
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(W));
      chk({tag, " product"}, 64'(p), 64'(exp));
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;
         @(negedge clk);
         chk({tag, " stall hold P"}, 64'(p), 64'(exp));
         chk({tag, " stall in_ready"}, {63'd0, in_ready}, 64'd0);
         chk({tag, " stall out_valid"}, {63'd0, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, {63'd0, out_valid}, 64'd0);
      chk({tag, " P retained"}, 64'(p), 64'(exp));
   endtask

   initial begin
      logic [2*W-1:0] got_p[3];
      int             got_c[3];
      int             nout;
      int             idx_in;
      int             seen;
      int             in0;
      int             out0;
      logic [W-1:0]   pa[3];
      logic [W-1:0]   pb[3];

      vecs[0] = '{16'd1232,  16'd1456,  0, 32'h001B5F00};
      vecs[1] = '{16'hFFFF,  16'hFFFF,  0, 32'hFFFE0001};
      vecs[2] = '{16'h0000,  16'h1234,  0, 32'h00000000};
      vecs[3] = '{16'h1234,  16'h0000,  0, 32'h00000000};
      vecs[4] = '{16'd3,     16'd5,    10, 32'd15};
      vecs[5] = '{16'h0001,  16'hFFFF,  2, 32'h0000FFFF};
      vecs[6] = '{16'h8000,  16'h8000,  0, 32'h40000000};
      vecs[7] = '{16'h00FF,  16'h0100,  1, 32'h0000FF00};
      vecs[8] = '{16'h8000,  16'h0002,  0, 32'h00010000};
      vecs[9] = '{16'hFFFF,  16'h0001,  3, 32'h0000FFFF};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset P", 64'(p), 64'd0);
      rst_n = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].exp,
                $sformatf("vec%0d", i));
      end

      // Reset during RUN: nonzero P beforehand so the clear is observable.
      run_op(16'd7, 16'd9, 0, 32'd63, "pre-reset");
      @(negedge clk);
      a = 16'd100; b = 16'd200; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("run busy", {63'd0, busy}, 64'd1);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun rst out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrun rst P", 64'(p), 64'd0);
      chk("midrun rst in_ready", {63'd0, in_ready}, 64'd1);
      chk("midrun rst busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      chk("no emit after reset", 64'(seen), 64'd0);

      // Back-to-back with IN_VALID held high and OUT_READY high
      pa[0] = 16'd11;     pb[0] = 16'd13;
      pa[1] = 16'hABCD;   pb[1] = 16'h1234;
      pa[2] = 16'hFFFF;   pb[2] = 16'h0002;
      nout = 0; idx_in = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (out_valid && nout < 3) begin
            got_p[nout] = p;
            got_c[nout] = c;
            nout++;
         end
         if (in_ready) begin
            if (idx_in < 3) begin
               a = pa[idx_in]; b = pb[idx_in]; in_valid = 1'b1;
               idx_in++;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b count", 64'(nout), 64'd3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("b2b product%0d", k), 64'(got_p[k]),
             64'(32'(pa[k]) * 32'(pb[k])));
      end
      chk("b2b spacing01", 64'(got_c[1] - got_c[0]), 64'(W + 2));
      chk("b2b spacing12", 64'(got_c[2] - got_c[1]), 64'(W + 2));

      // Random operands and stalls against A*B
      @(negedge clk);
      in0 = n_in; out0 = n_out;
      for (int r = 0; r < 1000; r++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 7) == 0) ra = '1;
         if ($urandom_range(0, 7) == 0) rb = '0;
         run_op(ra, rb, int'($urandom_range(0, 3)), 32'(ra) * 32'(rb),
                $sformatf("rand%0d a=%0h b=%0h", r, ra, rb));
      end
      @(negedge clk);
      chk("rand handshakes in", 64'(n_in - in0), 64'd1000);
      chk("rand handshakes out", 64'(n_out - out0), 64'd1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
